// File: rtl/multi_lane_auto_ctrl.sv
// Round-robin signal controller for NUM_LANES approaches: GREEN/YELLOW per served lane, others RED.
// Optional ALL_RED clearance interval between lanes enabled by defining ALL_RED_CLEAR_EN.
module multi_lane_auto_ctrl #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned TIME_W    = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [TIME_W-1:0]        green_time,
    input  logic [TIME_W-1:0]        yellow_time,
    input  logic [TIME_W-1:0]        clear_time,
    input  logic [NUM_LANES-1:0]     lane_req,
    output logic [2*NUM_LANES-1:0]   lights,
    output logic [$clog2(NUM_LANES)-1:0] active_lane,
    output logic [TIME_W-1:0]        phase_time,
    output logic [1:0]               state
);

    localparam int unsigned LANE_W = $clog2(NUM_LANES);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StGreen  = 2'b01,
        StYellow = 2'b10,
        StAllRed = 2'b11
    } state_e;

    state_e                  state_q, state_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [TIME_W-1:0]       phase_q, phase_d;
    logic [2*NUM_LANES-1:0]  lights_q, lights_d;
    logic [LANE_W-1:0]       next_lane;
    logic                    found;
    logic                    phase_end;

    // A requested time of 0 still yields a one-cycle phase.
    function automatic logic [TIME_W-1:0] load_time(input logic [TIME_W-1:0] t);
        return (t == '0) ? '0 : t - TIME_W'(1);
    endfunction

`ifndef ALL_RED_CLEAR_EN
    logic unused_clear_time;
    assign unused_clear_time = ^clear_time;
`endif

    // First requesting lane after the active one; keep the active lane if none.
    always_comb begin
        next_lane = lane_q;
        found     = 1'b0;
        for (int k = 1; k < int'(NUM_LANES); k++) begin
            int idx;
            idx = (int'(lane_q) + k) % int'(NUM_LANES);
            if (!found && lane_req[idx]) begin
                found     = 1'b1;
                next_lane = LANE_W'(idx);
            end
        end
    end

    assign phase_end = (phase_q == '0);

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        phase_d = phase_q;
        if (!enable) begin
            state_d = StIdle;
            lane_d  = '0;
            phase_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StGreen;
                    lane_d  = '0;
                    phase_d = load_time(green_time);
                end
                StGreen: begin
                    if (phase_end) begin
                        state_d = StYellow;
                        phase_d = load_time(yellow_time);
                    end else begin
                        phase_d = phase_q - TIME_W'(1);
                    end
                end
                StYellow: begin
                    if (phase_end) begin
`ifdef ALL_RED_CLEAR_EN
                        state_d = StAllRed;
                        phase_d = load_time(clear_time);
`else
                        state_d = StGreen;
                        lane_d  = next_lane;
                        phase_d = load_time(green_time);
`endif
                    end else begin
                        phase_d = phase_q - TIME_W'(1);
                    end
                end
`ifdef ALL_RED_CLEAR_EN
                StAllRed: begin
                    if (phase_end) begin
                        state_d = StGreen;
                        lane_d  = next_lane;
                        phase_d = load_time(green_time);
                    end else begin
                        phase_d = phase_q - TIME_W'(1);
                    end
                end
`endif
                default: begin
                    state_d = StIdle;
                    lane_d  = '0;
                    phase_d = '0;
                end
            endcase
        end
    end

    // Lamp decode from next state keeps lights aligned with the state register.
    always_comb begin
        lights_d = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (state_d == StIdle) begin
                lights_d[2*i +: 2] = 2'b00;
            end else if (int'(lane_d) == i && state_d == StGreen) begin
                lights_d[2*i +: 2] = 2'b11;
            end else if (int'(lane_d) == i && state_d == StYellow) begin
                lights_d[2*i +: 2] = 2'b10;
            end else begin
                lights_d[2*i +: 2] = 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            lane_q   <= '0;
            phase_q  <= '0;
            lights_q <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            phase_q  <= phase_d;
            lights_q <= lights_d;
        end
    end

    assign state       = state_q;
    assign active_lane = lane_q;
    assign phase_time  = phase_q;
    assign lights      = lights_q;

endmodule
